// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter
// Shares one single-port RGB565 framebuffer RAM between VGA scan-out reads,
// renderer writes and a whole-buffer clear engine. Scan-out reads own every
// display slot (first pixel of each upscaled source pixel). Clear writes and
// renderer writes fill the remaining cycles. Syncs and the valid flag are
// delayed two cycles so they line up with the RAM read latency.
//
// state  | meaning
// IDLE   | hold register may drain; a latched clear waits for the hold to empty
// CLEAR  | every free cycle writes the clear colour and advances clr_addr
module fb_scan_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              valid_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              clr_start,
  input  logic [15:0]       clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       pix_data,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              valid_out
);

  localparam int                NPIX      = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] NPIX_A    = ADDR_W'(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t state_q, state_d;

  // write hold register
  logic              hold_full;
  logic [ADDR_W-1:0] hold_addr;
  logic [15:0]       hold_data;

  // clear engine
  logic              clr_pend;
  logic [ADDR_W-1:0] clr_addr;
  logic [15:0]       clr_color_q;

  // scan pipeline
  logic              slot_d1;
  logic              valid_d1;
  logic              hsync_d1;
  logic              vsync_d1;
  logic [15:0]       word_reg;

  // per-cycle decisions from the arbiter
  logic              clr_step;
  logic              clr_enter;
  logic              hold_drain;

  logic              slot;
  logic [9:0]        src_x;
  logic [9:0]        src_y;
  logic [ADDR_W-1:0] slot_addr;
  logic              wr_fire;
  logic              wr_in_range;

  // A slot is the first display pixel of every upscaled source pixel; the
  // other pixels of the group reuse the word fetched in the slot.
  assign slot      = valid_in && (pix_x[SCALE_LOG2-1:0] == '0);
  assign src_x     = pix_x >> SCALE_LOG2;
  assign src_y     = pix_y >> SCALE_LOG2;
  assign slot_addr = ADDR_W'(src_y) * FB_W_A + ADDR_W'(src_x);

  // Writes are refused while the hold is occupied or a clear is pending or
  // running, so the clear never races a renderer write.
  assign wr_ready    = !hold_full && (state_q == ST_IDLE) && !clr_pend;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_addr < NPIX_A);

  // State register for the clear FSM.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next state: slot read > clear write > hold write > idle.
  always_comb begin
    state_d    = state_q;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    clr_step   = 1'b0;
    clr_enter  = 1'b0;
    hold_drain = 1'b0;

    if (slot) begin
      ram_addr = slot_addr;
    end else if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = clr_color_q;
      clr_step  = 1'b1;
      if (clr_addr == LAST_ADDR) begin
        state_d = ST_IDLE;
      end
    end else if (hold_full) begin
      ram_we     = 1'b1;
      ram_addr   = hold_addr;
      ram_wdata  = hold_data;
      hold_drain = 1'b1;
    end

    // A latched clear starts only once the hold has drained.
    if ((state_q == ST_IDLE) && clr_pend && !hold_full) begin
      state_d   = ST_CLEAR;
      clr_enter = 1'b1;
    end
  end

  // Hold register: filled on accept, emptied when its write reaches the RAM.
  // Out-of-range addresses complete the handshake but never fill the hold.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_full <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      if (hold_drain) begin
        hold_full <= 1'b0;
      end
      if (wr_fire && wr_in_range) begin
        hold_full <= 1'b1;
        hold_addr <= wr_addr;
        hold_data <= wr_data;
      end
    end
  end

  // Clear engine bookkeeping: latch request, walk addresses, drop busy after
  // the final address has been written.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clr_pend    <= 1'b0;
      clr_busy    <= 1'b0;
      clr_addr    <= '0;
      clr_color_q <= '0;
    end else begin
      if (clr_start && !clr_busy) begin
        clr_pend    <= 1'b1;
        clr_busy    <= 1'b1;
        clr_color_q <= clr_color;
      end
      if (clr_enter) begin
        clr_pend <= 1'b0;
        clr_addr <= '0;
      end
      if (clr_step) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          clr_busy <= 1'b0;
        end
      end
    end
  end

  // Scan-out pipeline: RAM data arrives one cycle after the slot, the pixel
  // register adds the second cycle; syncs and valid follow the same delay.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_d1   <= 1'b0;
      valid_d1  <= 1'b0;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
      word_reg  <= '0;
      pix_data  <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      slot_d1   <= slot;
      valid_d1  <= valid_in;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
      valid_out <= valid_d1;
      if (slot_d1) begin
        word_reg <= ram_rdata;
      end
      if (valid_d1) begin
        pix_data <= slot_d1 ? ram_rdata : word_reg;
      end else begin
        pix_data <= '0;
      end
    end
  end

endmodule
